// File: rtl/effect_chain_if.sv
// effect_chain_if: controller read handshake plus processed-sample outputs.
// master = environment/controller side, slave = effect_chain side.
interface effect_chain_if #(
  parameter int d_width = 16
);
  logic               i_data_ready;
  logic [d_width-1:0] i_data;
  logic               o_read_enable;
  logic               i_read_done;
  logic [d_width-1:0] o_data;
  logic               o_data_valid;
  logic               o_timeout;

  modport master (
    output i_data_ready,
    output i_data,
    output i_read_done,
    input  o_read_enable,
    input  o_data,
    input  o_data_valid,
    input  o_timeout
  );

  modport slave (
    input  i_data_ready,
    input  i_data,
    input  i_read_done,
    output o_read_enable,
    output o_data,
    output o_data_valid,
    output o_timeout
  );
endinterface

// File: rtl/effect_chain.sv
// effect_chain: fetch one sample per handshake, apply bypass/clip/crush/gain.
// Optional EFFECT_SOFTCLIP_EN turns clip mode into a soft knee.
module effect_chain #(
  parameter int d_width    = 16,
  parameter int CRUSH_BITS = 4,
  parameter int GAIN_SHIFT = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         sw,
  input  logic [d_width-1:0] i_threshold,
  effect_chain_if.slave      bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = d_width + GAIN_SHIFT;

  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [d_width-1:0] S_MAX =
    {1'b0, {(d_width-1){1'b1}}};
  localparam logic [d_width-1:0] S_MIN =
    {1'b1, {(d_width-1){1'b0}}};
  localparam logic [d_width-1:0] CRUSH_MASK =
    ~((d_width'(1) << CRUSH_BITS) - d_width'(1));

  localparam logic signed [GW-1:0] G_MAX =
    {{(GAIN_SHIFT+1){1'b0}}, {(d_width-1){1'b1}}};
  localparam logic signed [GW-1:0] G_MIN =
    {{(GAIN_SHIFT+1){1'b1}}, {(d_width-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PROC,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]             r_cnt;
  logic signed [d_width-1:0] r_x;
  logic [1:0]                r_sw;
  logic [d_width-1:0]        r_thr;
  logic [d_width-1:0]        r_data;
  logic                      r_rd_en;
  logic                      r_valid;
  logic                      r_timeout;

  logic                      w_rd_en;
  logic                      w_valid;
  logic                      w_timeout;
  logic                      w_capture;

  logic [d_width-1:0]        w_t;
  logic [d_width-1:0]        w_mag;
  logic [d_width-1:0]        w_clip;
  logic [d_width-1:0]        w_crush;
  logic signed [GW-1:0]      w_gx;
  logic [d_width-1:0]        w_gain;
  logic [d_width-1:0]        w_result;
`ifdef EFFECT_SOFTCLIP_EN
  logic [d_width-1:0]        w_knee;
`endif

  assign bus.o_read_enable = r_rd_en;
  assign bus.o_data_valid  = r_valid;
  assign bus.o_timeout     = r_timeout;
  assign bus.o_data        = r_data;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a WAIT at the limit count always abandons.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.i_data_ready) w_next = S_REQ;
      S_REQ:  w_next = S_WAIT;
      S_WAIT: begin
        if (r_cnt == TO_MAX)       w_next = S_IDLE;
        else if (bus.i_read_done)  w_next = S_PROC;
      end
      S_PROC: w_next = S_OUT;
      S_OUT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode, one cycle ahead of the registered strobes.
  always_comb begin
    w_rd_en   = (w_next == S_REQ);
    w_valid   = (w_next == S_OUT);
    w_capture = (r_state == S_WAIT) && (w_next == S_PROC);
    w_timeout = (r_state == S_WAIT) && !bus.i_read_done
             && (r_cnt == TO_LAST);
  end

  // Registered strobes so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en   <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_rd_en   <= w_rd_en;
      r_valid   <= w_valid;
      r_timeout <= w_timeout;
    end
  end

  // Wait counter: cleared in REQ, counts idle WAIT cycles up to the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT && !bus.i_read_done
                 && r_cnt != TO_MAX) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Capture sample, mode and threshold together so later changes don't leak in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x   <= '0;
      r_sw  <= '0;
      r_thr <= '0;
    end else if (w_capture) begin
      r_x   <= $signed(bus.i_data);
      r_sw  <= sw;
      r_thr <= i_threshold;
    end
  end

  // Effect datapath on the captured values.
  always_comb begin
    w_t   = (r_thr > S_MAX) ? S_MAX : r_thr;
    w_mag = r_x[d_width-1] ? (~r_x) + d_width'(1) : r_x;
    w_clip = r_x;
`ifdef EFFECT_SOFTCLIP_EN
    w_knee = w_t + ((w_mag - w_t) >> 2);
    if (w_knee > S_MAX) w_knee = S_MAX;
    if (w_mag > w_t)
      w_clip = r_x[d_width-1] ? (~w_knee) + d_width'(1) : w_knee;
`else
    if (w_mag > w_t)
      w_clip = r_x[d_width-1] ? (~w_t) + d_width'(1) : w_t;
`endif
    w_crush = r_x & CRUSH_MASK;
    w_gx    = {{GAIN_SHIFT{r_x[d_width-1]}}, r_x} <<< GAIN_SHIFT;
    if (w_gx > G_MAX)      w_gain = S_MAX;
    else if (w_gx < G_MIN) w_gain = S_MIN;
    else                   w_gain = w_gx[d_width-1:0];
    unique case (r_sw)
      2'b00:   w_result = r_x;
      2'b01:   w_result = w_clip;
      2'b10:   w_result = w_crush;
      default: w_result = w_gain;
    endcase
  end

  // Result register, loaded at the end of PROC and held until the next one.
  always_ff @(posedge clk) begin
    if (reset)                  r_data <= '0;
    else if (r_state == S_PROC) r_data <= w_result;
  end

endmodule
